// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for the parametrised synchronous FIFO:
//                default geometry, read-mode enumeration and the pointer
//                type for the default geometry (shared with the scoreboard).
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package fifo_pkg;

    // Default geometry: 32-bit words, 2**5 = 32 entries.
    localparam int c_default_data_width = 32;
    localparam int c_default_addr_width = 5;

    // Read-port behaviour.
    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, data one cycle after request
        FIFO_FWFT = 1'b1    // head word presented combinationally
    } fifo_mode_e;

    // Pointer for the default geometry: address bits plus one wrap bit.
    typedef logic [c_default_addr_width:0] fifo_ptr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port storage array, DEPTH x DATA_WIDTH.
//                Synchronous write port, asynchronous read port. No reset:
//                contents are only meaningful where the pointers say so.
//  Ports       : clk        - write clock
//                i_wr_en    - write strobe
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_addr  - read address
//                o_rd_data  - read data (combinational from i_rd_addr)
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ADDR_WIDTH = c_default_addr_width
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_sync_fifo
//  Description : Single-clock FIFO with configurable width/depth, all DEPTH
//                entries usable, occupancy count, programmable almost-full /
//                almost-empty flags, overflow/underflow pulses and a
//                selectable standard or first-word-fall-through read port.
//  Ports       : clk          - single clock, all state changes on posedge
//                reset        - asynchronous active-high reset
//                Wr_enable    - write request
//                Read_enable  - read request (pop of head word in FWFT mode)
//                data_in      - write data
//                data_out     - read data
//                data_valid   - data_out holds valid read data
//                full/empty   - count == DEPTH / count == 0
//                almost_full  - count >= AFULL_THRESH
//                almost_empty - count <= AEMPTY_THRESH
//                count        - occupancy 0..DEPTH
//                overflow     - pulse: write requested while full
//                underflow    - pulse: read requested while empty
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = c_default_data_width,
    parameter int ADDR_WIDTH    = c_default_addr_width,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_enable,
    input  logic                  Read_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int         c_depth = 2 ** ADDR_WIDTH;
    localparam fifo_mode_e c_mode  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    // Exact-width constants keep pointer arithmetic free of width casts.
    localparam logic [ADDR_WIDTH:0] c_ptr_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_depth_cnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (ADDR_WIDTH < 1) begin : g_chk_addr_width
        $fatal(1, "param_sync_fifo: ADDR_WIDTH must be >= 1");
    end

    if (!((AEMPTY_THRESH > 0) && (AEMPTY_THRESH < AFULL_THRESH) &&
          (AFULL_THRESH <= c_depth))) begin : g_chk_thresh
        $fatal(1, "param_sync_fifo: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    if ((FWFT != 0) && (FWFT != 1)) begin : g_chk_fwft
        $fatal(1, "param_sync_fifo: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------------
    // Pointers and decoded status
    // ------------------------------------------------------------------------
    // One extra MSB per pointer distinguishes full from empty when the
    // address bits coincide, so every entry can be used.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  r_overflow;
    logic                  r_underflow;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // A full FIFO refuses writes even when a read happens in the same cycle;
    // there is deliberately no pass-through path.
    assign w_wr_accept = Wr_enable   && !w_full;
    assign w_rd_accept = Read_enable && !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Error pulses: high for exactly the cycle after the rejected request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= Wr_enable   && w_full;
            r_underflow <= Read_enable && w_empty;
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (int'(w_count) >= AFULL_THRESH);
    assign almost_empty = (int'(w_count) <= AEMPTY_THRESH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
    if (c_mode == FIFO_STD) begin : g_std_read
        logic [DATA_WIDTH-1:0] r_data_out;
        logic                  r_data_valid;

        // The head word is captured on the accepting edge; data_out then
        // holds until the next accepted read.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data_out   <= '0;
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_data_out <= w_rd_data;
                end
            end
        end

        assign data_out   = r_data_out;
        assign data_valid = r_data_valid;
    end else begin : g_fwft_read
        // Head word is always on the output; Read_enable acts as the pop.
        // data_out is don't-care while data_valid is low.
        assign data_out   = w_rd_data;
        assign data_valid = !w_empty;
    end

    // ------------------------------------------------------------------------
    // Embedded protocol assertions
    // ------------------------------------------------------------------------
    a_wr_ptr_step : assert property (@(posedge clk) disable iff (reset)
        w_wr_accept |=> (r_wr_ptr == ($past(r_wr_ptr) + c_ptr_one)));

    a_rd_ptr_step : assert property (@(posedge clk) disable iff (reset)
        w_rd_accept |=> (r_rd_ptr == ($past(r_rd_ptr) + c_ptr_one)));

    a_not_full_and_empty : assert property (@(posedge clk) disable iff (reset)
        !(w_full && w_empty));

    a_count_bounded : assert property (@(posedge clk) disable iff (reset)
        (w_count <= c_depth_cnt));

endmodule : param_sync_fifo
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_sync_fifo
//  Description : Self-checking bench for param_sync_fifo. A standard-read
//                and an FWFT instance share one stimulus stream and are
//                compared every cycle against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_sync_fifo;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int AFULL  = 30;
    localparam int AEMPTY = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din   = '0;

    // Standard-read instance outputs
    logic [DW-1:0] s_data_out;
    logic          s_data_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [AW:0]   s_count;
    // FWFT instance outputs
    logic [DW-1:0] f_data_out;
    logic          f_data_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [AW:0]   f_count;

    param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFULL),
                      .AEMPTY_THRESH(AEMPTY), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en),
        .data_in(din), .data_out(s_data_out), .data_valid(s_data_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_afull),
        .almost_empty(s_aempty), .count(s_count), .overflow(s_ovf),
        .underflow(s_udf)
    );

    param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFULL),
                      .AEMPTY_THRESH(AEMPTY), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en),
        .data_in(din), .data_out(f_data_out), .data_valid(f_data_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf),
        .underflow(f_udf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents plus the registered read outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_out   = '0;
    bit            m_valid = 1'b0;
    bit            m_ovf   = 1'b0;
    bit            m_udf   = 1'b0;

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one clock edge's worth of behaviour to the model, using the
    // inputs currently being driven and the state before the edge.
    task automatic model_edge();
        int  n        = q.size();
        bit  was_full = (n == DEPTH);
        bit  was_emp  = (n == 0);
        m_ovf = wr_en && was_full;
        m_udf = rd_en && was_emp;
        if (rd_en && !was_emp) begin
            m_out   = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr_en && !was_full) q.push_back(din);
    endtask

    task automatic model_reset();
        q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic check_all(input string ph);
        int n = q.size();
        check_value({ph, " s_count"},  s_count,  n);
        check_value({ph, " s_full"},   s_full,   (n == DEPTH));
        check_value({ph, " s_empty"},  s_empty,  (n == 0));
        check_value({ph, " s_afull"},  s_afull,  (n >= AFULL));
        check_value({ph, " s_aempty"}, s_aempty, (n <= AEMPTY));
        check_value({ph, " s_ovf"},    s_ovf,    m_ovf);
        check_value({ph, " s_udf"},    s_udf,    m_udf);
        check_value({ph, " s_valid"},  s_data_valid, m_valid);
        check_value({ph, " s_dout"},   s_data_out,   m_out);
        check_value({ph, " f_count"},  f_count,  n);
        check_value({ph, " f_full"},   f_full,   (n == DEPTH));
        check_value({ph, " f_empty"},  f_empty,  (n == 0));
        check_value({ph, " f_afull"},  f_afull,  (n >= AFULL));
        check_value({ph, " f_aempty"}, f_aempty, (n <= AEMPTY));
        check_value({ph, " f_ovf"},    f_ovf,    m_ovf);
        check_value({ph, " f_udf"},    f_udf,    m_udf);
        check_value({ph, " f_valid"},  f_data_valid, (n != 0));
        if (n != 0) check_value({ph, " f_dout"}, f_data_out, q[0]);
    endtask

    // Drive inputs, advance one edge, then compare #1 after the edge.
    task automatic cycle(input bit we, input bit re, input logic [DW-1:0] d,
                         input string ph);
        wr_en = we;
        rd_en = re;
        din   = d;
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    // Called at edge+1: asserts reset between edges, checks outputs before
    // the next edge, holds reset over that edge, releases after it.
    task automatic async_reset(input string ph);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all(ph);
        @(posedge clk);
        #2;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all({ph, "_rel"});
    endtask

    initial begin
        // Reset state
        #2;
        check_all("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Fill with 1..32, no reads; one extra write overflows
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
        check_value("fill_full_count", s_count, 32);
        cycle(1'b1, 1'b0, 32'hFFFF_FFFF, "overflow");
        check_value("overflow_pulse", s_ovf, 1'b1);
        cycle(1'b0, 1'b0, '0, "overflow_clear");

        // Drain 32 words in order; one extra read underflows
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0, "drain");
            check_value("drain_order", s_data_out, i);
        end
        cycle(1'b0, 1'b1, '0, "underflow");
        check_value("underflow_hold", s_data_out, 32'h20);

        // Simultaneous read/write for 100 cycles at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $urandom, "pre5");
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, $urandom, "rw100");
        check_value("rw100_count", s_count, 5);

        // Both requests on empty, then on full
        while (q.size() > 0) cycle(1'b0, 1'b1, '0, "drain2");
        cycle(1'b1, 1'b1, 32'hA5A5_A5A5, "rw_empty");
        check_value("rw_empty_count", s_count, 1);
        while (q.size() < DEPTH) cycle(1'b1, 1'b0, $urandom, "fill2");
        cycle(1'b1, 1'b1, 32'hA5A5_A5A5, "rw_full");
        check_value("rw_full_count", s_count, 31);

        // FWFT fall-through of a single word
        while (q.size() > 0) cycle(1'b0, 1'b1, '0, "drain3");
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, "fwft_wr");
        check_value("fwft_head", f_data_out, 32'hDEAD_BEEF);
        check_value("fwft_valid", f_data_valid, 1'b1);
        cycle(1'b0, 1'b1, '0, "fwft_pop");
        check_value("fwft_empty", f_empty, 1'b1);

        // Asynchronous reset mid-burst at count 17
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, $urandom, "burst");
        wr_en = 1'b1;
        din   = $urandom;
        async_reset("mid_reset");
        cycle(1'b1, 1'b0, 32'h1234_5678, "post_wr");
        cycle(1'b0, 1'b1, '0, "post_rd");
        check_value("post_reset_word", s_data_out, 32'h1234_5678);

        // Randomised traffic, write-heavy then read-heavy
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40,
                  $urandom, "rand_a");
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 65,
                  $urandom, "rand_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_param_sync_fifo
`default_nettype wire
